// File: rtl/cernbe_vme_arbiter.sv
// cernbe_vme_arbiter
// Round-robin arbiter that shares one cern-be-vme slave register bank between
// m0 (host VME decode) and m1 (local sequencer). Single-cycle Rd/Wr strobes are
// captured into a per-master pending slot, serialised onto the slave port one
// transaction at a time, and Done/RdData are routed back to the owning master.
// Optional feature macro: CERNBE_ARB_TIMEOUT_EN (forced completion with error
// after TIMEOUT_CYCLES cycles in ISSUE+WAIT without a matching slave Done).
module cernbe_vme_arbiter #(
    parameter int unsigned ADDR_W         = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [ADDR_W:1]   m0_VMEAddr_i,
    input  logic [15:0]       m0_VMEWrData_i,
    input  logic              m0_VMERdMem_i,
    input  logic              m0_VMEWrMem_i,
    output logic [15:0]       m0_VMERdData_o,
    output logic              m0_VMERdDone_o,
    output logic              m0_VMEWrDone_o,
    output logic              m0_Err_o,
    input  logic [ADDR_W:1]   m1_VMEAddr_i,
    input  logic [15:0]       m1_VMEWrData_i,
    input  logic              m1_VMERdMem_i,
    input  logic              m1_VMEWrMem_i,
    output logic [15:0]       m1_VMERdData_o,
    output logic              m1_VMERdDone_o,
    output logic              m1_VMEWrDone_o,
    output logic              m1_Err_o,
    output logic [ADDR_W:1]   VMEAddr_o,
    output logic [15:0]       VMEWrData_o,
    output logic              VMERdMem_o,
    output logic              VMEWrMem_o,
    input  logic [15:0]       VMERdData_i,
    input  logic              VMERdDone_i,
    input  logic              VMEWrDone_i,
    output logic              Busy_o
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("cernbe_vme_arbiter: TIMEOUT_CYCLES must be 1..65535");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Master request inputs gathered into index-able form
    logic [1:0]      rd_stb;
    logic [1:0]      wr_stb;
    logic [ADDR_W:1] req_addr  [2];
    logic [15:0]     req_wdata [2];

    // Pending slots, one per master
    logic [1:0]      pend_q, pend_d;
    logic [1:0]      slot_wr_q;
    logic [ADDR_W:1] slot_addr_q  [2];
    logic [15:0]     slot_wdata_q [2];
    logic [1:0]      cap;

    // Transaction currently owning the slave port
    logic            last_q;
    logic            owner_q;
    logic            cur_wr_q;
    logic [ADDR_W:1] cur_addr_q;
    logic [15:0]     cur_wdata_q;

    // Master-side completion registers
    logic [1:0]      rd_done_q;
    logic [1:0]      wr_done_q;
    logic [1:0]      err_q;
    logic [15:0]     rdata_q [2];

    logic            busy;
    logic            grant;
    logic            grant_id;
    logic            done_match;
    logic            tmo_hit;
    logic            complete;
    logic            timed_out;

    assign busy       = (state_q != S_IDLE);
    assign done_match = cur_wr_q ? VMEWrDone_i : VMERdDone_i;

    // Pack per-master request ports into arrays
    always_comb begin
        rd_stb       = {m1_VMERdMem_i, m0_VMERdMem_i};
        wr_stb       = {m1_VMEWrMem_i, m0_VMEWrMem_i};
        req_addr[0]  = m0_VMEAddr_i;
        req_addr[1]  = m1_VMEAddr_i;
        req_wdata[0] = m0_VMEWrData_i;
        req_wdata[1] = m1_VMEWrData_i;
    end

`ifdef CERNBE_ARB_TIMEOUT_EN
    logic [15:0] cnt_q;

    assign tmo_hit = (cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // Cycles spent in ISSUE+WAIT for the current grant
    always_ff @(posedge Clk) begin
        if (Rst || grant) begin
            cnt_q <= '0;
        end else if (busy) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // Strobe accepted only when that master has nothing pending or in flight
    always_comb begin
        cap = '0;
        for (int unsigned n = 0; n < 2; n++) begin
            cap[n] = (rd_stb[n] | wr_stb[n]) & ~pend_q[n] &
                     ~(busy & (owner_q == 1'(n)));
        end
    end

    // Arbitration FSM: next state, grant selection and completion detect
    always_comb begin
        state_d   = state_q;
        grant     = 1'b0;
        grant_id  = 1'b0;
        complete  = 1'b0;
        timed_out = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (|pend_q) begin
                    grant    = 1'b1;
                    grant_id = (&pend_q) ? ~last_q : pend_q[1];
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE, S_WAIT: begin
                if (done_match) begin
                    complete = 1'b1;
                    state_d  = S_IDLE;
                end else if (tmo_hit) begin
                    complete  = 1'b1;
                    timed_out = 1'b1;
                    state_d   = S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Grant clears the winner's pending bit; capture and grant never hit the same slot
    always_comb begin
        pend_d = pend_q;
        if (grant) begin
            pend_d[grant_id] = 1'b0;
        end
        pend_d = pend_d | cap;
    end

    // FSM state register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pending slot capture
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pend_q    <= '0;
            slot_wr_q <= '0;
            for (int unsigned n = 0; n < 2; n++) begin
                slot_addr_q[n]  <= '0;
                slot_wdata_q[n] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            for (int unsigned n = 0; n < 2; n++) begin
                if (cap[n]) begin
                    slot_addr_q[n]  <= req_addr[n];
                    slot_wdata_q[n] <= req_wdata[n];
                    slot_wr_q[n]    <= wr_stb[n];
                end
            end
        end
    end

    // Load the granted slot onto the slave port and record ownership
    always_ff @(posedge Clk) begin
        if (Rst) begin
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            cur_wr_q    <= 1'b0;
            cur_addr_q  <= '0;
            cur_wdata_q <= '0;
        end else if (grant) begin
            last_q      <= grant_id;
            owner_q     <= grant_id;
            cur_wr_q    <= slot_wr_q[grant_id];
            cur_addr_q  <= slot_addr_q[grant_id];
            cur_wdata_q <= slot_wdata_q[grant_id];
        end
    end

    // Route completion pulses and read data back to the owner
    always_ff @(posedge Clk) begin
        if (Rst) begin
            rd_done_q <= '0;
            wr_done_q <= '0;
            err_q     <= '0;
            for (int unsigned n = 0; n < 2; n++) begin
                rdata_q[n] <= '0;
            end
        end else begin
            for (int unsigned n = 0; n < 2; n++) begin
                rd_done_q[n] <= complete & ~cur_wr_q & (owner_q == 1'(n));
                wr_done_q[n] <= complete &  cur_wr_q & (owner_q == 1'(n));
                err_q[n]     <= complete &  timed_out & (owner_q == 1'(n));
            end
            if (complete && !cur_wr_q) begin
                rdata_q[owner_q] <= timed_out ? 16'hDEAD : VMERdData_i;
            end
        end
    end

    assign VMEAddr_o      = cur_addr_q;
    assign VMEWrData_o    = cur_wdata_q;
    assign VMERdMem_o     = (state_q == S_ISSUE) & ~cur_wr_q;
    assign VMEWrMem_o     = (state_q == S_ISSUE) &  cur_wr_q;
    assign Busy_o         = busy;

    assign m0_VMERdData_o = rdata_q[0];
    assign m0_VMERdDone_o = rd_done_q[0];
    assign m0_VMEWrDone_o = wr_done_q[0];
    assign m0_Err_o       = err_q[0];
    assign m1_VMERdData_o = rdata_q[1];
    assign m1_VMERdDone_o = rd_done_q[1];
    assign m1_VMEWrDone_o = wr_done_q[1];
    assign m1_Err_o       = err_q[1];

endmodule
